// File: rtl/multicycle_controller.sv
// Multicycle RISC-style control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing,
// retired-instruction counter and halt/illegal handling.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   run                start/continue request (sampled in IDLE and at retire)
//   instruction[31:0]  instruction word, captured in FETCH when mem_ready=1
//   mem_ready          memory access completes this cycle
//   pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_reg,
//   alu_src_imm, branch, jump, halted, trap   control outputs
//   alu_op[ALU_OP_W-1:0]   ALU operation code
//   state[3:0]         current state encoding
//   instr_count[CNT_W-1:0] retired-instruction counter (wraps)
//
// Build option: define CTRL_ILLEGAL_TRAP_EN to send illegal instructions to
// a sticky TRAP state; otherwise they retire as NOPs and trap is tied 0.

module multicycle_controller #(
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [31:0]         instruction,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_reg,
    output logic                alu_src_imm,
    output logic                branch,
    output logic                jump,
    output logic                halted,
    output logic                trap,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [3:0]          state,
    output logic [CNT_W-1:0]    instr_count
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_EXEC_I  = 4'd4,
        S_EXEC_BR = 4'd5,
        S_MEM     = 4'd6,
        S_WB      = 4'd7,
        S_HALT    = 4'd8,
        S_TRAP    = 4'd9
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       opcode_q, funct_q;
    logic [CNT_W-1:0] count_q;
    logic             retire;

    // Only opcode and funct fields drive sequencing.
    logic unused_instr;
    assign unused_instr = ^instruction[25:6];

    // Classification always uses the captured fields, never the live bus.
    logic is_rtype, r_ok, is_lw, is_sw, is_addi, is_beq, is_j, is_halt;

    assign is_rtype = (opcode_q == 6'h00);
    assign r_ok     = is_rtype && ((funct_q == 6'h20) ||
                                   (funct_q == 6'h22) ||
                                   (funct_q == 6'h2a));
    assign is_lw    = (opcode_q == 6'h23);
    assign is_sw    = (opcode_q == 6'h2b);
    assign is_addi  = (opcode_q == 6'h08);
    assign is_beq   = (opcode_q == 6'h04);
    assign is_j     = (opcode_q == 6'h02);
    assign is_halt  = (opcode_q == 6'h3f);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            opcode_q <= 6'h00;
            funct_q  <= 6'h00;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && mem_ready) begin
                opcode_q <= instruction[31:26];
                funct_q  <= instruction[5:0];
            end
            if (retire)
                count_q <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_reg     = 1'b0;
        alu_src_imm = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        halted      = 1'b0;
        alu_op      = '0;

        unique case (state_q)
            S_IDLE: begin
                if (run)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    r_ok:                      state_d = S_EXEC_R;
                    (is_lw | is_sw | is_addi): state_d = S_EXEC_I;
                    is_beq:                    state_d = S_EXEC_BR;
                    is_halt:                   state_d = S_HALT;
                    is_j: begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        // illegal encodings behave as a NOP
                        retire = 1'b1;
`endif
                    end
                endcase
            end
            S_EXEC_R: begin
                unique case (funct_q)
                    6'h22:   alu_op = ALU_OP_W'(1);
                    6'h2a:   alu_op = ALU_OP_W'(4);
                    default: alu_op = ALU_OP_W'(0);
                endcase
                state_d = S_WB;
            end
            S_EXEC_I: begin
                alu_src_imm = 1'b1;
                state_d     = (is_lw || is_sw) ? S_MEM : S_WB;
            end
            S_EXEC_BR: begin
                alu_op = ALU_OP_W'(6);
                branch = 1'b1;
                retire = 1'b1;
            end
            S_MEM: begin
                mem_read  = is_lw;
                mem_write = !is_lw;
                if (mem_ready) begin
                    if (is_lw)
                        state_d = S_WB;
                    else
                        retire = 1'b1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                reg_dst   = is_rtype;
                mem_reg   = is_lw;
                retire    = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // run is only consulted at the retire point
        if (retire)
            state_d = run ? S_FETCH : S_IDLE;
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign trap = (state_q == S_TRAP);
`else
    assign trap = 1'b0;
`endif

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: per-instruction phase model feeding
// a per-cycle expectation queue, plus literal latency/count checks.

module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n, run, mem_ready;
    logic [31:0] instruction;
    logic        pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst;
    logic        mem_reg, alu_src_imm, branch, jump, halted, trap;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic [15:0] instr_count;

    always #5 clk = ~clk;

    multicycle_controller #(.ALU_OP_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instruction(instruction),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_reg(mem_reg), .alu_src_imm(alu_src_imm),
        .branch(branch), .jump(jump), .halted(halted), .trap(trap),
        .alu_op(alu_op), .state(state), .instr_count(instr_count)
    );

    localparam logic [11:0] PCW  = 12'h800, IRW = 12'h400, MR  = 12'h200;
    localparam logic [11:0] MW   = 12'h100, RW  = 12'h080, RD  = 12'h040;
    localparam logic [11:0] MREG = 12'h020, ASI = 12'h010, BR  = 12'h008;
    localparam logic [11:0] JMP  = 12'h004, HLT = 12'h002, TRP = 12'h001;

    wire [11:0] dut_outs = {pc_write, ir_write, mem_read, mem_write,
                            reg_write, reg_dst, mem_reg, alu_src_imm,
                            branch, jump, halted, trap};

    typedef struct {
        logic [3:0]  st;
        logic [11:0] outs;
        logic [2:0]  alu;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        ce;
    logic [15:0] m_count = '0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, req);
        end
    endtask

    // per-cycle comparison against the model queue
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk("state", 32'(state), 32'(ce.st));
            chk("ctrl", 32'(dut_outs), 32'(ce.outs));
            chk("alu_op", 32'(alu_op), 32'(ce.alu));
            chk("count", 32'(instr_count), 32'(ce.cnt));
        end
    end

    // observed FETCH-to-retire length of the last retired instruction
    int          lat = 0, last_lat = 0;
    logic [15:0] prev_cnt = '0;
    always @(negedge clk) begin
        if (instr_count != prev_cnt) begin
            last_lat = lat;
            lat = 0;
        end
        prev_cnt = instr_count;
        if (!rst_n)
            lat = 0;
        else if (state != 4'd0)
            lat++;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic [3:0] st, input logic [11:0] o,
                      input logic [2:0] a);
        exp_q.push_back('{st, o, a, m_count});
    endtask

    task automatic idle(input int n, input logic last_run);
        for (int i = 0; i < n; i++) begin
            step;
            run = (i == n - 1) ? last_run : 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            ex(4'd0, 12'h000, 3'd0);
        end
    endtask

    // Drives one instruction from its first FETCH cycle and queues what
    // every cycle must look like. run is held inverted except at retire.
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int fw, input int mw,
                            input logic run_after, input bit abort_mem);
        bit rt, lw, sw, ai, bq, jj, hh, ill, last;
        logic [2:0] ra;
        rt = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2a);
        lw = (op == 6'h23);
        sw = (op == 6'h2b);
        ai = (op == 6'h08);
        bq = (op == 6'h04);
        jj = (op == 6'h02);
        hh = (op == 6'h3f);
        ill = !(rt || lw || sw || ai || bq || jj || hh);
        ra = (fn == 6'h22) ? 3'd1 : (fn == 6'h2a) ? 3'd4 : 3'd0;

        for (int i = 0; i <= fw; i++) begin
            step;
            run = ~run_after;
            mem_ready = (i == fw);
            instruction = {op, 20'($urandom), fn};
            ex(4'd1, (i == fw) ? (MR | PCW | IRW) : MR, 3'd0);
        end

        step;
        instruction = $urandom;
        mem_ready = 1'($urandom_range(0, 1));
        run = ~run_after;
        if (jj) begin
            run = run_after;
            ex(4'd2, JMP | PCW, 3'd0);
            m_count++;
            return;
        end
        if (hh) begin
            ex(4'd2, 12'h000, 3'd0);
            return;
        end
        if (ill) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            ex(4'd2, 12'h000, 3'd0);
            repeat (3) begin
                step;
                run = 1'($urandom_range(0, 1));
                ex(4'd9, TRP, 3'd0);
            end
`else
            run = run_after;
            ex(4'd2, 12'h000, 3'd0);
            m_count++;
`endif
            return;
        end
        ex(4'd2, 12'h000, 3'd0);

        if (bq) begin
            step;
            run = run_after;
            ex(4'd5, BR, 3'd6);
            m_count++;
            return;
        end
        if (rt) begin
            step;
            instruction = $urandom;
            ex(4'd3, 12'h000, ra);
            step;
            run = run_after;
            ex(4'd7, RW | RD, 3'd0);
            m_count++;
            return;
        end

        step;
        instruction = $urandom;
        ex(4'd4, ASI, 3'd0);
        if (ai) begin
            step;
            run = run_after;
            ex(4'd7, RW, 3'd0);
            m_count++;
            return;
        end

        for (int i = 0; i <= mw; i++) begin
            step;
            last = (i == mw) && !abort_mem;
            mem_ready = last;
            run = (last && sw) ? run_after : ~run_after;
            ex(4'd6, lw ? MR : MW, 3'd0);
            if (abort_mem)
                return;
        end
        if (sw) begin
            m_count++;
            return;
        end
        step;
        run = run_after;
        ex(4'd7, RW | MREG, 3'd0);
        m_count++;
    endtask

    // asynchronous reset in the middle of a cycle
    task automatic do_reset;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_outs", 32'(dut_outs), 32'd0);
        m_count = '0;
        step;
        ex(4'd0, 12'h000, 3'd0);
        step;
        ex(4'd0, 12'h000, 3'd0);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        run = 1'b0;
        mem_ready = 1'b0;
        instruction = '0;
        #1;
        chk("por_state", 32'(state), 32'd0);
        chk("por_count", 32'(instr_count), 32'd0);
        step;
        ex(4'd0, 12'h000, 3'd0);
        step;
        ex(4'd0, 12'h000, 3'd0);
        #2;
        rst_n = 1'b1;

        // add, zero-wait
        idle(2, 1'b1);
        do_instr(6'h00, 6'h20, 0, 0, 1'b0, 1'b0);
        idle(3, 1'b0);
        chk("add_count", 32'(instr_count), 32'd1);
        chk("add_latency", 32'(last_lat), 32'd4);

        // lw with three MEM wait cycles
        idle(1, 1'b1);
        do_instr(6'h23, 6'h00, 0, 3, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("lw_latency", 32'(last_lat), 32'd8);
        chk("lw_count", 32'(instr_count), 32'd2);

        // sub with two FETCH wait cycles
        idle(1, 1'b1);
        do_instr(6'h00, 6'h22, 2, 0, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("sub_wait_latency", 32'(last_lat), 32'd6);

        // back-to-back mix
        idle(1, 1'b1);
        do_instr(6'h00, 6'h2a, 0, 0, 1'b1, 1'b0);
        do_instr(6'h08, 6'h11, 1, 0, 1'b1, 1'b0);
        do_instr(6'h2b, 6'h00, 0, 1, 1'b1, 1'b0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        do_instr(6'h3e, 6'h00, 0, 0, 1'b1, 1'b0);
        chk("trap_count", 32'(instr_count), 32'd6);
        chk("trap_flag", 32'(trap), 32'd1);
        do_reset();
`else
        do_instr(6'h3e, 6'h00, 0, 0, 1'b1, 1'b0);
        do_instr(6'h00, 6'h21, 0, 0, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("illegal_nop_count", 32'(instr_count), 32'd8);
`endif

        // reset in the middle of a stalled sw
        idle(1, 1'b1);
        do_instr(6'h2b, 6'h00, 0, 2, 1'b1, 1'b1);
        do_reset();

        // beq, j, halt with run held high
        idle(2, 1'b1);
        do_instr(6'h04, 6'h00, 0, 0, 1'b1, 1'b0);
        do_instr(6'h02, 6'h00, 0, 0, 1'b1, 1'b0);
        do_instr(6'h3f, 6'h00, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step;
            run = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            ex(4'd8, HLT, 3'd0);
        end
        chk("halt_count", 32'(instr_count), 32'd2);
        chk("halted", 32'(halted), 32'd1);

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
